preamble_tx: RTL and testbench

PREAMBLE_TX -- requirements
Module: preamble_tx

---
 rtl/preamble_tx.sv | 86 ++++++++
 tb/tb_preamble_tx.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/preamble_tx.sv
// preamble_tx: prepends nrep repetitions of a programmable preamble table to each payload frame,
// then appends GAP_LEN zero samples.
module preamble_tx #(
    parameter int DATA_WIDTH = 16,
    parameter int PER_LEN    = 64,
    parameter int GAP_LEN    = 16,
    localparam int AW = $clog2(PER_LEN),
    localparam int GW = (GAP_LEN > 1) ? $clog2(GAP_LEN) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic [7:0]            nrep,
    input  logic                  cfg_we,
    input  logic [AW-1:0]         cfg_addr,
    input  logic [DATA_WIDTH-1:0] cfg_idata,
    input  logic [DATA_WIDTH-1:0] cfg_qdata,
    input  logic [DATA_WIDTH-1:0] in_itdata,
    input  logic [DATA_WIDTH-1:0] in_qtdata,
    input  logic                  in_tvalid,
    input  logic                  in_tlast,
    output logic                  in_tready,
    output logic [DATA_WIDTH-1:0] out_itdata,
    output logic [DATA_WIDTH-1:0] out_qtdata,
    output logic                  out_tvalid,
    output logic                  out_tlast,
    input  logic                  out_tready,
    output logic                  preamble_active,
    output logic                  frame_start
);
    typedef enum logic [1:0] {IDLE, PREAMBLE, PAYLOAD, GAP} state_t;
    state_t                  state;
    logic [AW-1:0]           idx;
    logic [7:0]              rep;
    logic [7:0]              nrep_l;
    logic [GW-1:0]           gcnt;
    logic [2*DATA_WIDTH-1:0] tbl [PER_LEN];
    logic                    xfer;
    assign xfer = out_tvalid && out_tready;
    // Asynchronous table read: a write this cycle is only visible from the next cycle on.
    always_comb begin
        out_tvalid      = (state == PAYLOAD) ? in_tvalid : (state != IDLE);
        out_tlast       = (state == PAYLOAD) && in_tlast;
        in_tready       = (state == PAYLOAD) && out_tready;
        preamble_active = (state == PREAMBLE);
        out_itdata      = (state == PAYLOAD) ? in_itdata :
                          (state == PREAMBLE) ? tbl[idx][2*DATA_WIDTH-1:DATA_WIDTH] : '0;
        out_qtdata      = (state == PAYLOAD) ? in_qtdata :
                          (state == PREAMBLE) ? tbl[idx][DATA_WIDTH-1:0] : '0;
    end
    always_ff @(posedge clk)
        if (cfg_we) tbl[cfg_addr] <= {cfg_idata, cfg_qdata};
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            state       <= IDLE;
            idx         <= '0;
            rep         <= '0;
            gcnt        <= '0;
            nrep_l      <= '0;
            frame_start <= 1'b0;
        end else begin
            frame_start <= 1'b0;
            case (state)
                IDLE: if (in_tvalid) begin
                    nrep_l      <= nrep;
                    frame_start <= 1'b1;
                    state       <= (nrep != 8'd0) ? PREAMBLE : PAYLOAD;
                end
                PREAMBLE: if (xfer) begin
                    if (idx == AW'(PER_LEN - 1)) begin
                        idx <= '0;
                        rep <= (rep == nrep_l - 8'd1) ? 8'd0 : rep + 8'd1;
                        if (rep == nrep_l - 8'd1) state <= PAYLOAD;
                    end else idx <= idx + 1'b1;
                end
                PAYLOAD: if (in_tvalid && out_tready && in_tlast)
                    state <= (GAP_LEN > 0) ? GAP : IDLE;
                GAP: if (xfer) begin
                    gcnt <= (gcnt == GW'(GAP_LEN - 1)) ? '0 : gcnt + 1'b1;
                    if (gcnt == GW'(GAP_LEN - 1)) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_preamble_tx.sv
// tb_preamble_tx: directed frame sequences against a table model and hand-derived sample order.
module tb_preamble_tx;
    localparam int DW = 16, PL = 4, GL = 2;
    logic          clk = 1'b0;
    logic          reset, clear, cfg_we, in_tvalid, in_tlast, out_tready;
    logic          out_tvalid, out_tlast, in_tready, preamble_active, frame_start;
    logic [7:0]    nrep;
    logic [1:0]    cfg_addr;
    logic [DW-1:0] cfg_idata, cfg_qdata, in_itdata, in_qtdata, out_itdata, out_qtdata;
    logic [DW-1:0] tbl_m [PL];
    int            vectors = 0, miscompares = 0;

    always #5 clk = ~clk;

    preamble_tx #(.DATA_WIDTH(DW), .PER_LEN(PL), .GAP_LEN(GL)) dut (
        .clk(clk), .reset(reset), .clear(clear), .nrep(nrep),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_idata(cfg_idata), .cfg_qdata(cfg_qdata),
        .in_itdata(in_itdata), .in_qtdata(in_qtdata), .in_tvalid(in_tvalid), .in_tlast(in_tlast),
        .in_tready(in_tready), .out_itdata(out_itdata), .out_qtdata(out_qtdata),
        .out_tvalid(out_tvalid), .out_tlast(out_tlast), .out_tready(out_tready),
        .preamble_active(preamble_active), .frame_start(frame_start)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        vectors++;
        assert (obs === exp_v) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_chk();
        in_tvalid = 1'b0;
        #1;
        chk("idle_valid0", 32'(out_tvalid), 32'd0);
        tick();
        chk("idle_valid1", 32'(out_tvalid), 32'd0);
        chk("idle_ready", 32'(in_tready), 32'd0);
    endtask

    // One frame: nr preamble periods, pl payload samples, GL gap zeros; optional table write at cycle wcyc.
    task automatic frame(input int nr, input int pl, input bit rnd, input bit b2b,
                         input int wcyc, input logic [1:0] waddr, input logic [DW-1:0] wval);
        int pos = 0, cnt = 0, k;
        int np = nr * PL;
        int tot = nr * PL + pl + GL;
        logic [DW-1:0] ei, eq;
        bit pay;
        in_tvalid = 1'b1; nrep = 8'(nr); in_itdata = 16'h100; in_qtdata = 16'h200;
        in_tlast = (pl == 1); out_tready = 1'b1;
        #1;
        chk("start_idle_valid", 32'(out_tvalid), 32'd0);
        chk("start_idle_fs", 32'(frame_start), 32'd0);
        tick();
        nrep = 8'hff;
        while (pos < tot && cnt < 400) begin
            out_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            k = pos - np;
            pay = (pos >= np) && (k < pl);
            if (pos >= np + pl) begin
                in_tvalid = b2b; in_tlast = 1'b0;
            end else if (k >= 0) begin
                in_itdata = 16'(256 + k); in_qtdata = 16'(512 + k); in_tlast = (k == pl - 1);
            end
            cfg_we = (cnt == wcyc); cfg_addr = waddr; cfg_idata = wval; cfg_qdata = wval;
            ei = pay ? 16'(256 + k) : (pos < np) ? tbl_m[pos % PL] : 16'd0;
            eq = pay ? 16'(512 + k) : (pos < np) ? tbl_m[pos % PL] : 16'd0;
            #1;
            chk("valid", 32'(out_tvalid), 32'd1);
            chk("idata", 32'(out_itdata), 32'(ei));
            chk("qdata", 32'(out_qtdata), 32'(eq));
            chk("tlast", 32'(out_tlast), 32'(pay && k == pl - 1));
            chk("in_tready", 32'(in_tready), 32'(pay && out_tready));
            chk("pre_active", 32'(preamble_active), 32'(pos < np));
            chk("frame_start", 32'(frame_start), 32'(cnt == 0));
            tick();
            cfg_we = 1'b0;
            if (cnt == wcyc) tbl_m[waddr] = wval;
            if (out_tready) pos++;
            cnt++;
        end
        chk("frame_done", 32'(pos), 32'(tot));
    endtask

    initial begin
        reset = 1'b1; clear = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_idata = '0; cfg_qdata = '0;
        in_tvalid = 1'b0; in_tlast = 1'b0; in_itdata = '0; in_qtdata = '0; out_tready = 1'b1; nrep = '0;
        tick(); tick();
        reset = 1'b0;
        #1;
        chk("rst_valid", 32'(out_tvalid), 32'd0);
        chk("rst_tlast", 32'(out_tlast), 32'd0);
        chk("rst_ready", 32'(in_tready), 32'd0);
        chk("rst_idata", 32'(out_itdata), 32'd0);
        chk("rst_qdata", 32'(out_qtdata), 32'd0);
        chk("rst_pre", 32'(preamble_active), 32'd0);
        chk("rst_fs", 32'(frame_start), 32'd0);
        for (int a = 0; a < PL; a++) begin
            cfg_we = 1'b1; cfg_addr = 2'(a); cfg_idata = 16'(a + 1); cfg_qdata = 16'(a + 1);
            tbl_m[a] = 16'(a + 1);
            tick();
        end
        cfg_we = 1'b0;
        frame(3, 5, 1'b0, 1'b0, -1, 2'd0, 16'd0);
        idle_chk();
        frame(0, 3, 1'b0, 1'b0, -1, 2'd0, 16'd0);
        idle_chk();
        frame(3, 5, 1'b1, 1'b0, -1, 2'd0, 16'd0);
        idle_chk();
        in_tvalid = 1'b1; nrep = 8'd3; in_itdata = 16'h100; in_qtdata = 16'h200; in_tlast = 1'b0;
        out_tready = 1'b1;
        tick();
        for (int i = 0; i < 6; i++) begin
            chk("clr_pre_data", 32'(out_itdata), 32'(tbl_m[i % PL]));
            if (i == 5) clear = 1'b1;
            tick();
        end
        clear = 1'b0; in_tvalid = 1'b0;
        #1;
        chk("clr_valid", 32'(out_tvalid), 32'd0);
        chk("clr_pre", 32'(preamble_active), 32'd0);
        tick();
        chk("clr_valid2", 32'(out_tvalid), 32'd0);
        frame(1, 2, 1'b0, 1'b0, -1, 2'd0, 16'd0);
        idle_chk();
        frame(2, 2, 1'b0, 1'b0, 0, 2'd1, 16'd9);
        idle_chk();
        frame(2, 2, 1'b0, 1'b0, 1, 2'd1, 16'd5);
        idle_chk();
        frame(1, 2, 1'b0, 1'b1, -1, 2'd0, 16'd0);
        frame(1, 2, 1'b0, 1'b0, -1, 2'd0, 16'd0);
        idle_chk();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
